// File: rtl/lfsr_seq_pkg.sv
// ------------------------------------------------------------------
// lfsr_seq_pkg: shared types and helpers for the LFSR sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package lfsr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    FILL = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Counter width wide enough to count to max(size, word_w) inclusive.
  function automatic int cnt_width(input int size, input int word_w);
    int m;
    m = (size > word_w) ? size : word_w;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_word_packer.sv
// ------------------------------------------------------------------
// lfsr_word_packer: collects captured LFSR bits into a held output word
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lfsr_word_packer
  import lfsr_seq_pkg::*;
#(
  parameter int WordW = 8,
  parameter int CntW  = cnt_width(WordW, WordW)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             capture_i,
  input  logic             bit_i,
  output logic             last_o,
  output logic [WordW-1:0] word_o
);

  logic [CntW-1:0]  bit_cnt_q;
  logic [WordW-1:0] shift_q;
  logic [WordW-1:0] shift_d;
  logic [WordW-1:0] word_q;

  assign last_o = capture_i && (bit_cnt_q == CntW'(WordW - 1));
  assign word_o = word_q;

  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < WordW; i++) begin
      if (bit_cnt_q == CntW'(i)) begin
        shift_d[i] = bit_i;
      end
    end
  end

  // The output word only changes on the final capture, so it stays put while offered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
    end else if (clear_i) begin
      bit_cnt_q <= '0;
    end else if (capture_i) begin
      shift_q <= shift_d;
      if (last_o) begin
        bit_cnt_q <= '0;
        word_q    <= shift_d;
      end else begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_seq_ctrl.sv
// ------------------------------------------------------------------
// lfsr_seq_ctrl: presets an external LFSR and streams its bits as words
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lfsr_seq_ctrl
  import lfsr_seq_pkg::*;
#(
  parameter int Size   = 16,
  parameter int WordW  = 8,
  parameter int CountW = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_seed_load_i,
  input  logic [Size-1:0]   cmd_seed_i,
  input  logic [CountW-1:0] cmd_count_i,
  input  logic              abort_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WordW-1:0]  word_data_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              lfsr_enable_o,
  output logic              lfsr_preset_enable_o,
  output logic              lfsr_preset_data_o,
  input  logic              lfsr_bit_i
);

  localparam int CntW = cnt_width(Size, WordW);

  state_e            state_q, state_d;
  logic [Size-1:0]   seed_q;
  logic [CountW-1:0] count_q;
  logic [CntW-1:0]   seed_idx_q;
  logic              done_q, done_d;
  logic              accept, handshake, capture, clear, fill_last;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  always_comb begin
    state_d              = state_q;
    done_d               = 1'b0;
    accept               = 1'b0;
    handshake            = 1'b0;
    capture              = 1'b0;
    clear                = 1'b0;
    cmd_ready_o          = 1'b0;
    word_valid_o         = 1'b0;
    lfsr_enable_o        = 1'b0;
    lfsr_preset_enable_o = 1'b0;
    lfsr_preset_data_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        clear       = 1'b1;
        if (cmd_valid_i) begin
          accept = 1'b1;
          if (cmd_seed_load_i)          state_d = SEED;
          else if (cmd_count_i != '0)   state_d = FILL;
          else                          done_d  = 1'b1;
        end
      end
      SEED: begin
        lfsr_enable_o        = 1'b1;
        lfsr_preset_enable_o = 1'b1;
        // seed_q shifts right each cycle, so bit 0 is always seed[idx].
        lfsr_preset_data_o   = seed_q[0];
        if (seed_idx_q == CntW'(Size - 1)) begin
          if (count_q != '0) begin
            state_d = FILL;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      FILL: begin
        lfsr_enable_o = 1'b1;
        capture       = 1'b1;
        if (fill_last) state_d = OUT;
      end
      OUT: begin
        word_valid_o = 1'b1;
        if (word_ready_i) begin
          handshake = 1'b1;
          if (count_q == CountW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_i && (state_q != IDLE)) begin
      state_d   = IDLE;
      done_d    = 1'b0;
      handshake = 1'b0;
      capture   = 1'b0;
      clear     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      count_q    <= '0;
      seed_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        seed_q     <= cmd_seed_i;
        count_q    <= cmd_count_i;
        seed_idx_q <= '0;
      end else if (state_q == SEED) begin
        seed_q     <= {1'b0, seed_q[Size-1:1]};
        seed_idx_q <= seed_idx_q + 1'b1;
      end
      if (handshake) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  lfsr_word_packer #(
    .WordW (WordW),
    .CntW  (CntW)
  ) u_packer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear),
    .capture_i (capture),
    .bit_i     (lfsr_bit_i),
    .last_o    (fill_last),
    .word_o    (word_data_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
// ------------------------------------------------------------------
// tb_lfsr_seq_ctrl: scoreboard bench with a 16-bit LFSR attached
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_lfsr_seq_ctrl;

  localparam int Size   = 16;
  localparam int WordW  = 8;
  localparam int CountW = 16;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic              cmd_seed_load_i = 1'b0;
  logic [Size-1:0]   cmd_seed_i = '0;
  logic [CountW-1:0] cmd_count_i = '0;
  logic              abort_i = 1'b0;
  logic              word_valid_o;
  logic              word_ready_i = 1'b0;
  logic [WordW-1:0]  word_data_o;
  logic              done_o;
  logic              busy_o;
  logic              lfsr_enable_o;
  logic              lfsr_preset_enable_o;
  logic              lfsr_preset_data_o;
  logic              lfsr_bit_i;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.Size(Size), .WordW(WordW), .CountW(CountW)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .cmd_valid_i          (cmd_valid_i),
    .cmd_ready_o          (cmd_ready_o),
    .cmd_seed_load_i      (cmd_seed_load_i),
    .cmd_seed_i           (cmd_seed_i),
    .cmd_count_i          (cmd_count_i),
    .abort_i              (abort_i),
    .word_valid_o         (word_valid_o),
    .word_ready_i         (word_ready_i),
    .word_data_o          (word_data_o),
    .done_o               (done_o),
    .busy_o               (busy_o),
    .lfsr_enable_o        (lfsr_enable_o),
    .lfsr_preset_enable_o (lfsr_preset_enable_o),
    .lfsr_preset_data_o   (lfsr_preset_data_o),
    .lfsr_bit_i           (lfsr_bit_i)
  );

  // Golden 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), serial preset into the top.
  function automatic logic lfsr_fb(input logic [15:0] s);
    return s[0] ^ s[2] ^ s[3] ^ s[5];
  endfunction

  logic [15:0] lfsr_q;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 16'h0001;
    else if (lfsr_enable_o)
      lfsr_q <= {(lfsr_preset_enable_o ? lfsr_preset_data_o : lfsr_fb(lfsr_q)), lfsr_q[15:1]};
  end
  assign lfsr_bit_i = lfsr_q[0];

  // Scoreboard state
  int n_chk = 0;
  int n_fail = 0;
  logic [WordW-1:0] exp_words[$];
  logic             exp_preset[$];
  int done_exp = 0;
  int done_seen = 0;
  logic [15:0] ref_state = 16'h0001;

  int cyc = 0;
  int accept_cyc = 0, first_valid_cyc = -1, last_hs_cyc = 0, done_cyc = 0;
  int preset_seen = 0, word_seen = 0, stall_cnt = 0;
  bit held = 1'b0;
  logic [WordW-1:0] held_data = '0;

  int  rmode = 0;
  logic man_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver applies a little after the edge so main can update man_ready first.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rmode == 0)      word_ready_i = 1'b1;
      else if (rmode == 1) word_ready_i = 1'($urandom_range(0, 1));
      else                 word_ready_i = man_ready;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_ni) begin
      if (cmd_valid_i && cmd_ready_o) begin
        accept_cyc      = cyc;
        first_valid_cyc = -1;
      end
      if (lfsr_preset_enable_o) begin
        preset_seen++;
        if (exp_preset.size() == 0) fail_now("preset_unexpected");
        else check("preset_bit", 32'(lfsr_preset_data_o), 32'(exp_preset.pop_front()));
      end
      if (word_valid_o) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (held) check("word_stable", 32'(word_data_o), 32'(held_data));
        if (word_ready_i) begin
          held        = 1'b0;
          last_hs_cyc = cyc;
          word_seen++;
          if (exp_words.size() == 0) fail_now("word_unexpected");
          else check("word_data", 32'(word_data_o), 32'(exp_words.pop_front()));
        end else begin
          held      = 1'b1;
          held_data = word_data_o;
          stall_cnt++;
          check("stall_lfsr_frozen", 32'(lfsr_enable_o), 32'd0);
        end
      end else begin
        held = 1'b0;
      end
      if (done_o) begin
        done_seen++;
        done_cyc = cyc;
        if (done_seen > done_exp) fail_now("done_unexpected");
        check("ready_after_done", 32'(cmd_ready_o), 32'd1);
      end
    end
  end

  // Entry and exit phase: 1 time unit after a rising edge.
  task automatic send_cmd(input bit sl, input logic [15:0] seed, input int cnt, input bit with_abort);
    int guard;
    logic [WordW-1:0] wd;
    guard = 0;
    while (!cmd_ready_o && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) fail_now("cmd_ready_timeout");
    if (sl) begin
      ref_state = seed;
      for (int i = 0; i < Size; i++) exp_preset.push_back(seed[i]);
    end
    for (int w = 0; w < cnt; w++) begin
      for (int b = 0; b < WordW; b++) begin
        wd[b]     = ref_state[0];
        ref_state = {lfsr_fb(ref_state), ref_state[15:1]};
      end
      exp_words.push_back(wd);
    end
    done_exp++;
    cmd_valid_i     = 1'b1;
    cmd_seed_load_i = sl;
    cmd_seed_i      = seed;
    cmd_count_i     = CountW'(cnt);
    abort_i         = with_abort;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    abort_i     = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done_seen < done_exp && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 2000) fail_now("done_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, w0, s0, d0;
    int guard;
    logic [15:0] rseed;

    // Reset
    rmode = 0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_word_valid", 32'(word_valid_o), 32'd0);
    check("rst_lfsr_enable", 32'(lfsr_enable_o), 32'd0);
    check("rst_preset_enable", 32'(lfsr_preset_enable_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    @(posedge clk); #1;

    // Seeded 3-word command with full timing checks
    p0 = preset_seen; w0 = word_seen;
    send_cmd(1'b1, 16'hACE1, 3, 1'b0);
    check("seed_busy", 32'(busy_o), 32'd1);
    wait_done();
    check("seed_presets", 32'(preset_seen - p0), 32'd16);
    check("seed_words", 32'(word_seen - w0), 32'd3);
    check("first_valid_latency", 32'(first_valid_cyc - accept_cyc), 32'd25);
    check("last_handshake_latency", 32'(last_hs_cyc - accept_cyc), 32'd43);
    check("done_after_handshake", 32'(done_cyc - last_hs_cyc), 32'd1);

    // Continue without seed: words 4 and 5 of the same stream
    p0 = preset_seen; w0 = word_seen;
    send_cmd(1'b0, 16'h0000, 2, 1'b0);
    wait_done();
    check("noseed_presets", 32'(preset_seen - p0), 32'd0);
    check("noseed_words", 32'(word_seen - w0), 32'd2);

    // Backpressure: 5 stalled cycles on the first word
    rmode = 2; man_ready = 1'b0;
    s0 = stall_cnt; w0 = word_seen;
    send_cmd(1'b1, 16'h1D2B, 2, 1'b0);
    guard = 0;
    while (!word_valid_o && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) fail_now("bp_valid_timeout");
    repeat (5) @(posedge clk);
    #1 man_ready = 1'b1;
    wait_done();
    check("bp_stalls", 32'(stall_cnt - s0), 32'd5);
    check("bp_words", 32'(word_seen - w0), 32'd2);
    rmode = 0;

    // Zero-count seeded command
    p0 = preset_seen; w0 = word_seen;
    send_cmd(1'b1, 16'h5A5A, 0, 1'b0);
    wait_done();
    check("zero_presets", 32'(preset_seen - p0), 32'd16);
    check("zero_words", 32'(word_seen - w0), 32'd0);
    check("zero_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);

    // Abort on the 4th FILL cycle
    w0 = word_seen; d0 = done_seen;
    send_cmd(1'b0, 16'h0000, 3, 1'b0);
    repeat (3) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    exp_words.delete();
    done_exp--;
    check("abort_idle", 32'(busy_o), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_words", 32'(word_seen - w0), 32'd0);
    check("abort_no_done", 32'(done_seen - d0), 32'd0);
    w0 = word_seen;
    send_cmd(1'b1, 16'hBEEF, 2, 1'b0);
    wait_done();
    check("post_abort_words", 32'(word_seen - w0), 32'd2);

    // Randomised commands with random backpressure
    rmode = 1;
    for (int k = 0; k < 8; k++) begin
      rseed = 16'($urandom_range(1, 16'hFFFF));
      send_cmd((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), rseed,
               int'($urandom_range(0, 4)), (k == 2));
      wait_done();
    end
    rmode = 0;

    repeat (5) @(posedge clk);
    #1;
    check("words_drained", 32'(exp_words.size()), 32'd0);
    check("presets_drained", 32'(exp_preset.size()), 32'd0);
    check("done_total", 32'(done_seen), 32'(done_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
